// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the opcode/funct constants, the FSM state encoding, the mux-select codes and the
// one-hot instruction flag bundle that ctrl_decode hands to the FSM.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJal   = 6'b000011;

  // Funct codes (IR[5:0]) for op == OpRtype
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnJr   = 6'b001000;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  // NPCsel
  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJal    = 2'b10;
  localparam logic [1:0] NpcJr     = 2'b11;

  // WRsel
  localparam logic [1:0] WrRt = 2'b00;
  localparam logic [1:0] WrRd = 2'b01;
  localparam logic [1:0] WrRa = 2'b10;

  // WDsel
  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdDm  = 2'b01;
  localparam logic [1:0] WdPc  = 2'b10;

  // ALUOp
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluOr  = 2'b10;

  // One-hot instruction flags; all zero means an undefined encoding (executed as a nop).
  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
  } instr_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle between the instruction register / datapath and the multi-cycle controller.
// master: datapath side, supplies op/funct/zero and consumes strobes and selects.
// slave : controller side, consumes op/funct/zero and drives strobes, selects and status.
interface multi_cycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             PCWr;
  logic             IRWr;
  logic [1:0]       NPCsel;
  logic [1:0]       WRsel;
  logic [1:0]       WDsel;
  logic             RFWr;
  logic             EXTOp;
  logic             Bsel;
  logic [1:0]       ALUOp;
  logic             LUIsel;
  logic             Slt;
  logic             DMWr;
  logic [2:0]       state;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    output op, funct, zero,
    input  PCWr, IRWr, NPCsel, WRsel, WDsel, RFWr, EXTOp, Bsel, ALUOp, LUIsel, Slt, DMWr,
    input  state, done, retired
  );

  modport slave (
    input  op, funct, zero,
    output PCWr, IRWr, NPCsel, WRsel, WDsel, RFWr, EXTOp, Bsel, ALUOp, LUIsel, Slt, DMWr,
    output state, done, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder.
// Inputs : op_i/funct_i from the latched IR.
// Outputs: one-hot instruction flags and the state-independent datapath selects
//          (NPCsel before the FETCH override, WRsel, WDsel, ALUOp, EXTOp, Bsel, LUIsel, Slt).
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_t     instr_o,
  output logic [1:0] npcsel_o,
  output logic [1:0] wrsel_o,
  output logic [1:0] wdsel_o,
  output logic [1:0] aluop_o,
  output logic       extop_o,
  output logic       bsel_o,
  output logic       luisel_o,
  output logic       slt_o
);

  logic   rtype;
  instr_t instr;

  assign rtype      = (op_i == OpRtype);
  assign instr.addu = rtype && (funct_i == FnAddu);
  assign instr.subu = rtype && (funct_i == FnSubu);
  assign instr.slt  = rtype && (funct_i == FnSlt);
  assign instr.jr   = rtype && (funct_i == FnJr);
  assign instr.ori  = (op_i == OpOri);
  assign instr.lw   = (op_i == OpLw);
  assign instr.sw   = (op_i == OpSw);
  assign instr.beq  = (op_i == OpBeq);
  assign instr.lui  = (op_i == OpLui);
  assign instr.jal  = (op_i == OpJal);

  assign instr_o = instr;

  always_comb begin
    npcsel_o = NpcPc4;
    wrsel_o  = WrRt;
    wdsel_o  = WdAlu;
    aluop_o  = AluAdd;
    extop_o  = 1'b0;
    bsel_o   = 1'b0;
    luisel_o = 1'b0;
    slt_o    = 1'b0;

    if (instr.addu || instr.subu || instr.slt) wrsel_o = WrRd;
    if (instr.subu || instr.beq)               aluop_o = AluSub;
    if (instr.slt)                             slt_o   = 1'b1;
    if (instr.ori) begin
      aluop_o = AluOr;
      bsel_o  = 1'b1;
    end
    if (instr.lui) begin
      luisel_o = 1'b1;
      bsel_o   = 1'b1;
    end
    // Loads and stores compute a sign-extended base+offset address.
    if (instr.lw || instr.sw) begin
      bsel_o  = 1'b1;
      extop_o = 1'b1;
    end
    if (instr.lw)  wdsel_o  = WdDm;
    if (instr.beq) npcsel_o = NpcBranch;
    if (instr.jal) begin
      npcsel_o = NpcJal;
      wrsel_o  = WrRa;
      wdsel_o  = WdPc;
    end
    if (instr.jr)  npcsel_o = NpcJr;
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencer, write-strobe decode and
// retired-instruction counter.
// Ports: clk, reset (synchronous, active high), bus (slave modport) carrying op/funct/zero in
//        and PCWr/IRWr/RFWr/DMWr strobes, mux selects, state, done and retired out.
module multi_cycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multi_cycle_ctrl_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  instr_t           instr;
  logic [1:0]       npcsel_dec;
  logic             pcwr, irwr, rfwr, dmwr, done;

  ctrl_decode u_decode (
    .op_i     (bus.op),
    .funct_i  (bus.funct),
    .instr_o  (instr),
    .npcsel_o (npcsel_dec),
    .wrsel_o  (bus.WRsel),
    .wdsel_o  (bus.WDsel),
    .aluop_o  (bus.ALUOp),
    .extop_o  (bus.EXTOp),
    .bsel_o   (bus.Bsel),
    .luisel_o (bus.LUIsel),
    .slt_o    (bus.Slt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = StFetch;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    rfwr    = 1'b0;
    dmwr    = 1'b0;
    done    = 1'b0;

    case (state_q)
      StFetch: begin
        irwr    = 1'b1;
        pcwr    = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (instr.jal) begin
          pcwr = 1'b1;
          rfwr = 1'b1;
          done = 1'b1;
        end else if (instr.jr) begin
          pcwr = 1'b1;
          done = 1'b1;
        end else if (instr == '0) begin
          done = 1'b1;  // undefined encoding retires as a nop
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (instr.beq) begin
          pcwr = bus.zero;
          done = 1'b1;
        end else if (instr.lw || instr.sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (instr.sw) begin
          dmwr = 1'b1;
          done = 1'b1;
        end else if (instr.lw) begin
          state_d = StWb;
        end
      end
      StWb: begin
        rfwr = 1'b1;
        done = 1'b1;
      end
      default: ;  // illegal codes: all strobes low, back to FETCH
    endcase

    // Reset aborts the current instruction without any side effect this cycle.
    if (reset) begin
      pcwr = 1'b0;
      irwr = 1'b0;
      rfwr = 1'b0;
      dmwr = 1'b0;
      done = 1'b0;
    end
  end

  assign bus.PCWr    = pcwr;
  assign bus.IRWr    = irwr;
  assign bus.RFWr    = rfwr;
  assign bus.DMWr    = dmwr;
  assign bus.done    = done;
  assign bus.NPCsel  = (state_q == StFetch) ? NpcPc4 : npcsel_dec;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule
